// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, shared ms tick, and per-channel debounce FSM
// producing clean level, press, release and long-hold pulses.
module btn_conditioner #(
    parameter int NUM_BTN        = 6,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 5000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold,
    output logic               tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [NUM_BTN-1:0] RAW_IDLE = {NUM_BTN{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        StReleased,
        StDebPress,
        StPressed,
        StDebRelease
    } state_e;

    logic [TW-1:0]      r_tick_cnt;
    logic               w_tick;
    logic [NUM_BTN-1:0] r_sync1, r_sync2;
    logic [NUM_BTN-1:0] w_s;

    state_e             r_state    [NUM_BTN];
    state_e             w_state_d  [NUM_BTN];
    logic [DW-1:0]      r_deb_cnt  [NUM_BTN];
    logic [DW-1:0]      w_deb_cnt_d[NUM_BTN];
    logic [DW-1:0]      w_deb_inc  [NUM_BTN];
    logic [HW-1:0]      r_hold_cnt [NUM_BTN];
    logic [HW-1:0]      w_hold_cnt_d[NUM_BTN];
    logic [HW-1:0]      w_hold_inc [NUM_BTN];
    logic [NUM_BTN-1:0] r_hold_done, w_hold_done_d;
    logic [NUM_BTN-1:0] r_level, w_level_d;
    logic [NUM_BTN-1:0] r_press, w_press_d;
    logic [NUM_BTN-1:0] r_release, w_release_d;
    logic [NUM_BTN-1:0] r_hold, w_hold_d;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_s    = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_sync1    <= RAW_IDLE;
            r_sync2    <= RAW_IDLE;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
        end
    end

    // An s change always takes priority over a coincident tick, so that tick is lost.
    always_comb begin
        w_hold_done_d = r_hold_done;
        w_level_d     = r_level;
        w_press_d     = '0;
        w_release_d   = '0;
        w_hold_d      = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_state_d[i]    = r_state[i];
            w_deb_cnt_d[i]  = r_deb_cnt[i];
            w_hold_cnt_d[i] = r_hold_cnt[i];
            w_deb_inc[i]    = r_deb_cnt[i] + DW'(1);
            w_hold_inc[i]   = r_hold_cnt[i] + HW'(1);
            case (r_state[i])
                StReleased: begin
                    if (w_s[i]) begin
                        w_state_d[i]   = StDebPress;
                        w_deb_cnt_d[i] = '0;
                    end
                end
                StDebPress: begin
                    if (!w_s[i]) begin
                        w_state_d[i] = StReleased;
                    end else if (w_tick) begin
                        w_deb_cnt_d[i] = w_deb_inc[i];
                        if (w_deb_inc[i] == DW'(DEBOUNCE_TICKS)) begin
                            w_state_d[i]     = StPressed;
                            w_level_d[i]     = 1'b1;
                            w_press_d[i]     = 1'b1;
                            w_hold_cnt_d[i]  = '0;
                            w_hold_done_d[i] = 1'b0;
                        end
                    end
                end
                StPressed: begin
                    if (!w_s[i]) begin
                        w_state_d[i]   = StDebRelease;
                        w_deb_cnt_d[i] = '0;
                    end else if (w_tick && !r_hold_done[i]) begin
                        w_hold_cnt_d[i] = w_hold_inc[i];
                        if (w_hold_inc[i] == HW'(HOLD_TICKS)) begin
                            w_hold_d[i]      = 1'b1;
                            w_hold_done_d[i] = 1'b1;
                        end
                    end
                end
                StDebRelease: begin
                    if (w_s[i]) begin
                        w_state_d[i] = StPressed;
                    end else if (w_tick) begin
                        w_deb_cnt_d[i] = w_deb_inc[i];
                        if (w_deb_inc[i] == DW'(DEBOUNCE_TICKS)) begin
                            w_state_d[i]    = StReleased;
                            w_level_d[i]    = 1'b0;
                            w_release_d[i]  = 1'b1;
                            w_hold_cnt_d[i] = '0;
                        end else if (!r_hold_done[i]) begin
                            // Hold timer keeps running through a release glitch.
                            w_hold_cnt_d[i] = w_hold_inc[i];
                            if (w_hold_inc[i] == HW'(HOLD_TICKS)) begin
                                w_hold_d[i]      = 1'b1;
                                w_hold_done_d[i] = 1'b1;
                            end
                        end
                    end
                end
                default: w_state_d[i] = StReleased;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i]    <= StReleased;
                r_deb_cnt[i]  <= '0;
                r_hold_cnt[i] <= '0;
            end
            r_hold_done <= '0;
            r_level     <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_hold      <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i]    <= w_state_d[i];
                r_deb_cnt[i]  <= w_deb_cnt_d[i];
                r_hold_cnt[i] <= w_hold_cnt_d[i];
            end
            r_hold_done <= w_hold_done_d;
            r_level     <= w_level_d;
            r_press     <= w_press_d;
            r_release   <= w_release_d;
            r_hold      <= w_hold_d;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_hold    = r_hold;
    assign tick        = w_tick;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: a streak-counting model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_btn_conditioner;

    localparam int NB   = 6;
    localparam int TDIV = 4;
    localparam int DEB  = 3;
    localparam int HOLD = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '1;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;
    logic          tick;

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN       (NB),
        .TICK_DIV      (TDIV),
        .DEBOUNCE_TICKS(DEB),
        .HOLD_TICKS    (HOLD),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .tick       (tick)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: accepted level flips after DEB ticks seen while the pressed input disagrees
    // with it and has not changed since the previous cycle.
    logic [NB-1:0] raw_d1, raw_d2, s_prev;
    logic [NB-1:0] m_level, m_press, m_rel, m_hold, m_done;
    logic          m_tick;
    int            streak[NB];
    int            hold_ticks[NB];
    int            m_edges;

    task automatic model_step(input logic rst, input logic [NB-1:0] raw);
        logic          tk;
        logic [NB-1:0] s;
        logic          stable;
        m_press = '0;
        m_rel   = '0;
        m_hold  = '0;
        if (rst) begin
            raw_d1  = '1;
            raw_d2  = '1;
            s_prev  = '0;
            m_level = '0;
            m_done  = '0;
            for (int i = 0; i < NB; i++) begin
                streak[i]     = 0;
                hold_ticks[i] = 0;
            end
            m_edges = 0;
            m_tick  = 1'b0;
            return;
        end
        tk = (m_edges % TDIV == TDIV - 1);
        s  = ~raw_d2;
        for (int i = 0; i < NB; i++) begin
            stable = (s[i] == s_prev[i]);
            if (s[i] != m_level[i]) begin
                if (!stable) streak[i] = 0;
                else if (tk) streak[i]++;
            end else begin
                streak[i] = 0;
            end
            if (streak[i] == DEB) begin
                streak[i]     = 0;
                hold_ticks[i] = 0;
                if (!m_level[i]) begin
                    m_level[i] = 1'b1;
                    m_press[i] = 1'b1;
                    m_done[i]  = 1'b0;
                end else begin
                    m_level[i] = 1'b0;
                    m_rel[i]   = 1'b1;
                end
            end else if (m_level[i] && stable && tk && !m_done[i]) begin
                hold_ticks[i]++;
                if (hold_ticks[i] == HOLD) begin
                    m_hold[i] = 1'b1;
                    m_done[i] = 1'b1;
                end
            end
        end
        s_prev  = s;
        raw_d2  = raw_d1;
        raw_d1  = raw;
        m_edges++;
        m_tick  = (m_edges % TDIV == TDIV - 1);
    endtask

    logic          p_reset;
    logic [NB-1:0] p_raw;
    bit            started = 1'b0;

    // Inputs change just after posedge, so the values seen here are the next edge's inputs.
    always @(negedge clk) begin
        if (started) begin
            model_step(p_reset, p_raw);
            check("level",   int'(btn_level),   int'(m_level));
            check("press",   int'(btn_press),   int'(m_press));
            check("release", int'(btn_release), int'(m_rel));
            check("hold",    int'(btn_hold),    int'(m_hold));
            check("tick",    int'(tick),        int'(m_tick));
        end
        p_reset = reset;
        p_raw   = btn_raw;
        started = 1'b1;
    end

    int cyc = 0;
    int n_press[NB], n_rel[NB], n_hold[NB], n_lvl[NB], t_press[NB], t_hold[NB];
    int n_both;

    task automatic clear();
        for (int i = 0; i < NB; i++) begin
            n_press[i] = 0;
            n_rel[i]   = 0;
            n_hold[i]  = 0;
            n_lvl[i]   = 0;
            t_press[i] = 0;
            t_hold[i]  = 0;
        end
        n_both = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NB; i++) begin
                if (btn_press[i]) begin n_press[i]++; t_press[i] = cyc; end
                if (btn_hold[i])  begin n_hold[i]++;  t_hold[i]  = cyc; end
                if (btn_release[i]) n_rel[i]++;
                if (btn_level[i])   n_lvl[i]++;
            end
            if (btn_press[3] && btn_press[5]) n_both++;
        end
    endtask

    task automatic drive(input logic [NB-1:0] v);
        @(posedge clk);
        #1 btn_raw = v;
    endtask

    int first_tick, second_tick, sum;

    initial begin
        clear();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({btn_level, btn_press, btn_release, btn_hold, tick}), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        first_tick  = 0;
        second_tick = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cyc++;
            if (tick) begin
                if (first_tick == 0) first_tick = k;
                else if (second_tick == 0) second_tick = k;
            end
        end
        check("first_tick_clk", first_tick, 4);
        check("second_tick_clk", second_tick, 8);

        // Clean press on channel 0.
        clear();
        drive(6'h3E);
        run(19);
        check("clean_press_cnt", n_press[0], 1);
        check("clean_level", int'(btn_level[0]), 1);
        check("clean_other_level", int'(btn_level[5:1]), 0);
        sum = 0;
        for (int i = 1; i < NB; i++) sum += n_press[i];
        check("clean_other_press", sum, 0);

        // Bouncing channel 2, then a steady press.
        clear();
        for (int k = 0; k < 14; k++) begin
            drive(btn_raw ^ 6'h04);
            run(3);
        end
        check("bounce_press_cnt", n_press[2], 0);
        check("bounce_level_cycles", n_lvl[2], 0);
        clear();
        drive(btn_raw & ~6'h04);
        run(20);
        check("bounce_settle_press", n_press[2], 1);

        // Long hold on channel 4.
        clear();
        drive(btn_raw & ~6'h10);
        run(80);
        check("hold4_press_cnt", n_press[4], 1);
        check("hold4_hold_cnt", n_hold[4], 1);
        check_range("hold4_gap", t_hold[4] - t_press[4], 36, 44);
        drive(btn_raw | 6'h10);
        run(25);
        check("hold4_release_cnt", n_rel[4], 1);

        // Release glitch on channel 1, then a full release.
        clear();
        drive(btn_raw & ~6'h02);
        run(20);
        check("glitch_press_cnt", n_press[1], 1);
        drive(btn_raw | 6'h02);
        run(5);
        drive(btn_raw & ~6'h02);
        run(40);
        check("glitch_release_cnt", n_rel[1], 0);
        check("glitch_level", int'(btn_level[1]), 1);
        check("glitch_hold_cnt", n_hold[1], 1);
        check_range("glitch_hold_gap", t_hold[1] - t_press[1], 36, 44);
        clear();
        drive(btn_raw | 6'h02);
        run(25);
        check("full_release_cnt", n_rel[1], 1);
        check("full_release_level", int'(btn_level[1]), 0);

        // Channels 3 and 5 together, then reset while held.
        clear();
        drive(btn_raw & ~6'h28);
        run(20);
        check("simul_press3", n_press[3], 1);
        check("simul_press5", n_press[5], 1);
        check("simul_same_cycle", n_both, 1);
        clear();
        @(posedge clk);
        #1 reset = 1'b1;
        run(2);
        check("rst_mid_level", int'(btn_level), 0);
        sum = 0;
        for (int i = 0; i < NB; i++) sum += n_rel[i];
        check("rst_mid_release", sum, 0);
        run(1);
        @(posedge clk);
        #1 reset = 1'b0;
        clear();
        run(25);
        check("after_rst_press3", n_press[3], 1);
        check("after_rst_press5", n_press[5], 1);
        check("after_rst_press0", n_press[0], 1);
        check("after_rst_release3", n_rel[3], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
